c17_pattern_tester: RTL and testbench

- Sequential test controller forming the stimulus/response end of the c17 netlist interface.
- Drives the five primary inputs of a c17 instance under test (golden, or a trojan-inserted variant) with an exhaustive ascending pattern sequence.
- Samples the two primary outputs and compares them against an internal golden c17 model.
- Reports mismatch count, first failing pattern and an accumulated failing-output mask, so the evolutionary detection flow can score candidate circuits in hardware.

---
 rtl/c17_pattern_tester.sv | 167 ++++++++++++++++
 tb/tb_c17_pattern_tester.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/c17_pattern_tester.sv
`default_nettype none
// ----------------------------------------------------------------------------
// c17_pattern_tester: exhaustive stimulus/response tester for a c17 netlist,
// compared against an internal golden model.                      Rev 1.0
// ----------------------------------------------------------------------------
module c17_pattern_tester #(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop_on_fail,
  output logic [4:0]       dut_in,
  input  logic [1:0]       dut_out,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [4:0]       first_fail_idx,
  output logic [1:0]       first_fail_obs,
  output logic [1:0]       fail_mask
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [3:0]       wait_q, wait_d;
  logic             stop_q, stop_d;
  logic [4:0]       dut_in_q, dut_in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       ffi_q, ffi_d;
  logic [1:0]       ffo_q, ffo_d;
  logic [1:0]       mask_q, mask_d;

  logic n10, n11, n16, n19;
  logic [1:0] golden, diff;
  logic mismatch;

  // Golden c17 evaluated on the index: bit4=N1, bit3=N2, bit2=N3, bit1=N6, bit0=N7
  always_comb begin
    n10    = ~(idx_q[4] & idx_q[2]);
    n11    = ~(idx_q[2] & idx_q[1]);
    n16    = ~(idx_q[3] & n11);
    n19    = ~(n11 & idx_q[0]);
    golden = {~(n10 & n16), ~(n16 & n19)};
    diff   = dut_out ^ golden;
    mismatch = (state_q == S_SAMPLE) && (diff != 2'b00);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    stop_d   = stop_q;
    dut_in_d = dut_in_q;
    fail_d   = fail_q;
    cnt_d    = cnt_q;
    ffi_d    = ffi_q;
    ffo_d    = ffo_q;
    mask_d   = mask_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          fail_d  = 1'b0;
          cnt_d   = '0;
          ffi_d   = '0;
          ffo_d   = '0;
          mask_d  = '0;
          stop_d  = stop_on_fail;
          idx_d   = '0;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        dut_in_d = idx_q;
        wait_d   = SETTLE_C;
        state_d  = (SETTLE_C != 4'd0) ? S_WAIT : S_SAMPLE;
      end
      S_WAIT: begin
        if (wait_q <= 4'd1) begin
          state_d = S_SAMPLE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          mask_d = mask_q | diff;
          fail_d = 1'b1;
          if (!fail_q) begin
            ffi_d = idx_q;
            ffo_d = dut_out;
          end
        end
        if ((idx_q == 5'd31) || (mismatch && stop_q)) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = S_APPLY;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_APPLY) || (state_d == S_WAIT) || (state_d == S_SAMPLE);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      wait_q   <= '0;
      stop_q   <= 1'b0;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      cnt_q    <= '0;
      ffi_q    <= '0;
      ffo_q    <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
      stop_q   <= stop_d;
      dut_in_q <= dut_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      cnt_q    <= cnt_d;
      ffi_q    <= ffi_d;
      ffo_q    <= ffo_d;
      mask_q   <= mask_d;
    end
  end

  assign dut_in         = dut_in_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign fail           = fail_q;
  assign mismatch_cnt   = cnt_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_obs = ffo_q;
  assign fail_mask      = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_c17_pattern_tester.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_c17_pattern_tester: directed bench with a behavioural c17 (golden/trojan)
// as the circuit under test and a queue of expected run results.   Rev 1.0
// ----------------------------------------------------------------------------
module tb_c17_pattern_tester;

  typedef struct {
    logic       fail;
    logic [5:0] cnt;
    logic [4:0] idx;
    logic [1:0] obs;
    logic [1:0] mask;
    logic [4:0] last_in;
    int         cycles;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start0, sof, trojan;
  logic [4:0] dut_in, dut_in0;
  logic [1:0] dut_out, dut_out0;
  logic busy, done, fail, busy0, done0, fail0;
  logic [5:0] mcnt, mcnt0;
  logic [4:0] ffi, ffi0;
  logic [1:0] ffo, ffo0, fmask, fmask0;

  int checks = 0;
  int failures = 0;
  res_t exp_q[$];
  logic [4:0] exp_in_q[$];

  function automatic logic [1:0] c17(input logic [4:0] v, input logic troj);
    logic n10, n11, n16, n19;
    n10 = ~(v[4] & v[2]);
    n11 = ~(v[2] & v[1]);
    n16 = ~(v[3] & n11);
    n19 = ~(n11 & v[0]);
    if (troj) n16 = 1'b1;
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  function automatic res_t model(input logic troj, input logic stop, input int settle);
    res_t r;
    r.fail = 0; r.cnt = 0; r.idx = 0; r.obs = 0; r.mask = 0; r.last_in = 0; r.cycles = 0;
    for (int k = 0; k < 32; k++) begin
      logic [1:0] o, x;
      o = c17(5'(k), troj);
      x = o ^ c17(5'(k), 1'b0);
      r.last_in = 5'(k);
      r.cycles  = (k + 1) * (2 + settle) + 1;
      if (x != 2'b00) begin
        if (!r.fail) begin
          r.idx = 5'(k);
          r.obs = o;
        end
        r.fail = 1'b1;
        r.cnt  = r.cnt + 6'd1;
        r.mask = r.mask | x;
        if (stop) break;
      end
    end
    return r;
  endfunction

  assign dut_out  = c17(dut_in, trojan);
  assign dut_out0 = c17(dut_in0, 1'b0);

  c17_pattern_tester #(.SETTLE(1), .CNT_W(6)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop_on_fail(sof),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .fail(fail),
    .mismatch_cnt(mcnt), .first_fail_idx(ffi), .first_fail_obs(ffo), .fail_mask(fmask)
  );

  c17_pattern_tester #(.SETTLE(0), .CNT_W(6)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .stop_on_fail(1'b0),
    .dut_in(dut_in0), .dut_out(dut_out0), .busy(busy0), .done(done0), .fail(fail0),
    .mismatch_cnt(mcnt0), .first_fail_idx(ffi0), .first_fail_obs(ffo0), .fail_mask(fmask0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string run, input res_t e);
    chk({run, "_fail"}, 32'(fail), 32'(e.fail));
    chk({run, "_cnt"}, 32'(mcnt), 32'(e.cnt));
    chk({run, "_ffi"}, 32'(ffi), 32'(e.idx));
    chk({run, "_ffo"}, 32'(ffo), 32'(e.obs));
    chk({run, "_mask"}, 32'(fmask), 32'(e.mask));
    chk({run, "_dut_in"}, 32'(dut_in), 32'(e.last_in));
  endtask

  // One run on the SETTLE=1 instance; poke adds ignored start pulses mid-run and in the done cycle
  task automatic run1(input string run, input logic troj, input logic stop, input logic poke);
    int cyc;
    res_t e;
    trojan = troj;
    exp_q.push_back(model(troj, stop, 1));
    @(negedge clk); start = 1'b1; sof = stop;
    @(negedge clk); start = 1'b0; sof = 1'b0;
    cyc = 1;
    chk({run, "_busy_after_start"}, 32'(busy), 32'd1);
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = (poke && cyc == 10);
    end
    start = 1'b0;
    e = exp_q.pop_front();
    chk({run, "_done_seen"}, 32'(done), 32'd1);
    chk({run, "_cycles"}, 32'(cyc), 32'(e.cycles));
    chk({run, "_busy_at_done"}, 32'(busy), 32'd0);
    check_res(run, e);
    if (poke) start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({run, "_done_one_cycle"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({run, "_no_restart"}, 32'(busy), 32'd0);
    check_res({run, "_hold"}, e);
  endtask

  initial begin
    res_t e;
    logic [4:0] seen[$];
    int n, bad, cyc;
    logic any_out;
    rst = 1'b1; start = 1'b0; start0 = 1'b0; sof = 1'b0; trojan = 1'b0;
    repeat (3) @(negedge clk);
    any_out = busy | done | fail | (|mcnt) | (|ffi) | (|ffo) | (|fmask) | (|dut_in);
    chk("reset_outputs", 32'(any_out), 32'd0);
    rst = 1'b0;

    run1("golden", 1'b0, 1'b0, 1'b0);
    run1("trojan", 1'b1, 1'b0, 1'b0);
    chk("trojan_cnt_abs", 32'(mcnt), 32'd11);
    chk("trojan_obs_abs", 32'(ffo), 32'd0);
    run1("trojan_stop", 1'b1, 1'b1, 1'b0);
    chk("stop_dut_in_abs", 32'(dut_in), 32'b01000);

    // Reset in the middle of a trojan run
    trojan = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (dut_in != 5'd12 && cyc < 200) begin @(negedge clk); cyc++; end
    chk("rst_reached_idx12", 32'(dut_in), 32'd12);
    rst = 1'b1;
    @(negedge clk);
    any_out = busy | done | fail | (|mcnt) | (|ffi) | (|ffo) | (|fmask) | (|dut_in);
    chk("rst_midrun_outputs", 32'(any_out), 32'd0);
    rst = 1'b0;
    any_out = 1'b0;
    repeat (5) begin @(negedge clk); any_out = any_out | done | busy; end
    chk("rst_no_done_no_busy", 32'(any_out), 32'd0);
    run1("after_rst", 1'b1, 1'b0, 1'b0);
    run1("poke", 1'b1, 1'b0, 1'b1);

    // SETTLE=0 instance: each pattern occupies an APPLY and a SAMPLE cycle
    for (int k = 0; k < 32; k++) exp_in_q.push_back(5'(k));
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    n = 0;
    while (busy0 && n < 200) begin seen.push_back(dut_in0); n++; @(negedge clk); end
    chk("settle0_busy_cycles", 32'(n), 32'd64);
    chk("settle0_done", 32'(done0), 32'd1);
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      logic [4:0] ev;
      ev = exp_in_q.pop_front();
      if (2 * k + 1 >= seen.size() || seen[2 * k + 1] !== ev) bad++;
      if (2 * k + 2 < seen.size() && seen[2 * k + 2] !== ev) bad++;
    end
    chk("settle0_order", 32'(bad), 32'd0);
    e = model(1'b0, 1'b0, 0);
    chk("settle0_fail", 32'(fail0), 32'(e.fail));
    chk("settle0_cnt", 32'(mcnt0), 32'(e.cnt));
    chk("settle0_mask", 32'(fmask0), 32'(e.mask));
    chk("settle0_ffi_ffo", 32'({ffi0, ffo0}), 32'd0);
    chk("settle0_last_in", 32'(dut_in0), 32'(e.last_in));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
